// File: rtl/fp_to_int64_if.sv
// fp_to_int64_if: operand/result handshake bundle for fp_to_int64.
// FP2INT_RMODE_EN adds the rmode rounding-mode field.
interface fp_to_int64_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] fp_in;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] int_out;
    logic        flag_invalid;
    logic        flag_inexact;
`ifdef FP2INT_RMODE_EN
    logic [1:0]  rmode;
    modport slave (input in_valid, fp_in, out_ready, rmode,
                   output in_ready, out_valid, int_out, flag_invalid, flag_inexact);
    modport master (output in_valid, fp_in, out_ready, rmode,
                    input in_ready, out_valid, int_out, flag_invalid, flag_inexact);
`else
    modport slave (input in_valid, fp_in, out_ready,
                   output in_ready, out_valid, int_out, flag_invalid, flag_inexact);
    modport master (output in_valid, fp_in, out_ready,
                    input in_ready, out_valid, int_out, flag_invalid, flag_inexact);
`endif
endinterface

// File: rtl/fp_to_int64.sv
// fp_to_int64: multi-cycle IEEE double to signed 64-bit integer with iterative alignment.
// FP2INT_RMODE_EN enables the rmode input (RNE/RTZ/RUP/RDN); otherwise RNE is fixed.
module fp_to_int64 #(
    parameter int SHIFT_STEP = 8
) (
    input logic         clk,
    input logic         rst_n,
    fp_to_int64_if.slave io
);
    typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;
    localparam logic [5:0]  STEP    = 6'(SHIFT_STEP);
    localparam logic [63:0] MAX_POS = 64'h7fff_ffff_ffff_ffff;
    localparam logic [63:0] MIN_NEG = 64'h8000_0000_0000_0000;

    state_t      state_q, state_d;
    logic [63:0] mag_q, mag_d, res_q, res_d;
    logic [5:0]  n_q, n_d, amt;
    logic [1:0]  rm_q, rm_d;
    logic        sign_q, sign_d, g_q, g_d, t_q, t_d, left_q, left_d, sat_q, sat_d;
    logic        inv_q, inv_d, inx_q, inx_d, inc;
    logic [10:0] ex, ee;
    logic [11:0] rn;
    logic [63:0] lo_mask, sum;

    assign ex      = io.fp_in[62:52];
    assign ee      = (ex == 11'd0) ? 11'd1 : ex;
    assign rn      = 12'd1075 - {1'b0, ee};
    assign amt     = (n_q < STEP) ? n_q : STEP;
    // bits shifted out below the new guard position
    assign lo_mask = (64'd1 << (amt - 6'd1)) - 64'd1;
    assign inc     = (rm_q == 2'b01) ? 1'b0 :
                     (rm_q == 2'b10) ? (g_q | t_q) & ~sign_q :
                     (rm_q == 2'b11) ? (g_q | t_q) & sign_q :
                     g_q & (t_q | mag_q[0]);
    assign sum     = mag_q + {63'd0, inc};

    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        res_d   = res_q;
        n_d     = n_q;
        rm_d    = rm_q;
        sign_d  = sign_q;
        g_d     = g_q;
        t_d     = t_q;
        left_d  = left_q;
        sat_d   = sat_q;
        inv_d   = inv_q;
        inx_d   = inx_q;
        case (state_q)
            IDLE: if (io.in_valid) begin
                sign_d = io.fp_in[63];
                mag_d  = {11'd0, ex != 11'd0, io.fp_in[51:0]};
                g_d    = 1'b0;
                t_d    = 1'b0;
                n_d    = 6'd0;
                left_d = 1'b0;
                sat_d  = 1'b0;
`ifdef FP2INT_RMODE_EN
                rm_d   = io.rmode;
`else
                rm_d   = 2'b00;
`endif
                // saturated magnitudes are chosen so the final negation yields the right code
                if (ex == 11'h7ff) begin
                    sat_d = 1'b1;
                    mag_d = (io.fp_in[63] || io.fp_in[51:0] != 52'd0) ? MIN_NEG : MAX_POS;
                end else if (ex >= 11'd1086) begin
                    sat_d = !(io.fp_in[63] && ex == 11'd1086 && io.fp_in[51:0] == 52'd0);
                    mag_d = io.fp_in[63] ? MIN_NEG : MAX_POS;
                end else if (ex >= 11'd1075) begin
                    left_d = 1'b1;
                    n_d    = 6'(ex - 11'd1075);
                end else if (rn > 12'd54) begin
                    mag_d = 64'd0;
                    t_d   = |io.fp_in[62:0];
                end else
                    n_d = 6'(rn);
                state_d = (n_d != 6'd0) ? SHIFT : ROUND;
            end
            SHIFT: begin
                mag_d   = left_q ? mag_q << amt : mag_q >> amt;
                g_d     = left_q ? g_q : mag_q[amt - 6'd1];
                t_d     = left_q ? t_q : t_q | g_q | (|(mag_q & lo_mask));
                n_d     = n_q - amt;
                state_d = (n_d == 6'd0) ? ROUND : SHIFT;
            end
            ROUND: begin
                res_d   = sign_q ? -sum : sum;
                inv_d   = sat_q;
                inx_d   = g_q | t_q;
                state_d = DONE;
            end
            DONE: if (io.out_ready) state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mag_q   <= 64'd0;
            res_q   <= 64'd0;
            n_q     <= 6'd0;
            rm_q    <= 2'b00;
            sign_q  <= 1'b0;
            g_q     <= 1'b0;
            t_q     <= 1'b0;
            left_q  <= 1'b0;
            sat_q   <= 1'b0;
            inv_q   <= 1'b0;
            inx_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            res_q   <= res_d;
            n_q     <= n_d;
            rm_q    <= rm_d;
            sign_q  <= sign_d;
            g_q     <= g_d;
            t_q     <= t_d;
            left_q  <= left_d;
            sat_q   <= sat_d;
            inv_q   <= inv_d;
            inx_q   <= inx_d;
        end
    end

    assign io.in_ready     = (state_q == IDLE);
    assign io.out_valid    = (state_q == DONE);
    assign io.int_out      = res_q;
    assign io.flag_invalid = inv_q;
    assign io.flag_inexact = inx_q;
endmodule

// File: tb/tb_fp_to_int64.sv
// tb_fp_to_int64: directed and random checks of fp_to_int64 (SHIFT_STEP 8 and 1) against a real-arithmetic model.
module tb_fp_to_int64;
    localparam logic [63:0] MAXP = 64'h7fff_ffff_ffff_ffff;
    localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;

    logic        clk = 1'b0, rst_n = 1'b1, sel = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [63:0] fp_in = 64'd0;
`ifdef FP2INT_RMODE_EN
    logic [1:0]  rmode = 2'b00;
`endif
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    fp_to_int64_if ia();
    fp_to_int64_if ib();
    assign ia.in_valid  = in_valid & ~sel;
    assign ib.in_valid  = in_valid & sel;
    assign ia.fp_in     = fp_in;
    assign ib.fp_in     = fp_in;
    assign ia.out_ready = out_ready & ~sel;
    assign ib.out_ready = out_ready & sel;
`ifdef FP2INT_RMODE_EN
    assign ia.rmode = rmode;
    assign ib.rmode = rmode;
`endif

    fp_to_int64 #(.SHIFT_STEP(8)) dut_a (.clk(clk), .rst_n(rst_n), .io(ia.slave));
    fp_to_int64 #(.SHIFT_STEP(1)) dut_b (.clk(clk), .rst_n(rst_n), .io(ib.slave));

    logic        rdy, ov, inv_o, inx_o;
    logic [63:0] iout;
    assign rdy   = sel ? ib.in_ready : ia.in_ready;
    assign ov    = sel ? ib.out_valid : ia.out_valid;
    assign iout  = sel ? ib.int_out : ia.int_out;
    assign inv_o = sel ? ib.flag_invalid : ia.flag_invalid;
    assign inx_o = sel ? ib.flag_inexact : ia.flag_inexact;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // reference: exact real arithmetic on |x|, rounding decided from the fractional part
    task automatic model(input logic [63:0] f, input logic [1:0] rm,
                         output logic [63:0] r, output logic inv, output logic inx);
        real x, a, ip, fr;
        logic s, up;
        logic [63:0] mag;
        s = f[63];
        inv = 1'b0;
        inx = 1'b0;
        if (f[62:52] == 11'h7ff) begin
            inv = 1'b1;
            r = (f[51:0] == 52'd0 && !s) ? MAXP : MINN;
        end else begin
            x = $bitstoreal(f);
            a = s ? -x : x;
            if (a >= 9223372036854775808.0) begin
                if (x == -9223372036854775808.0) r = MINN;
                else begin
                    inv = 1'b1;
                    r = s ? MINN : MAXP;
                end
            end else begin
                ip  = $floor(a);
                fr  = a - ip;
                inx = (fr != 0.0);
                mag = 64'(longint'(ip));
                up  = (rm == 2'd0) ? (fr > 0.5 || (fr == 0.5 && mag[0])) :
                      (rm == 2'd1) ? 1'b0 :
                      (rm == 2'd2) ? (inx && !s) : (inx && s);
                mag = mag + {63'd0, up};
                r = s ? -mag : mag;
            end
        end
    endtask

    function automatic int exp_lat(input logic [63:0] f, input int step);
        int e, n;
        e = (f[62:52] == 11'd0) ? 1 : int'(f[62:52]);
        n = (e >= 1086) ? 0 : (e >= 1075) ? e - 1075 : (1075 - e > 54) ? 0 : 1075 - e;
        return (n + step - 1) / step + 2;
    endfunction

    function automatic logic [63:0] gen();
        logic [63:0] f;
        int k;
        f = {$urandom, $urandom};
        k = $urandom_range(0, 9);
        if (k == 1) begin
            f[62:52] = 11'h7ff;
            if ($urandom_range(0, 1) == 0) f[51:0] = 52'd0;
        end else if (k == 9) f[62:0] = 63'd0;
        else if (k >= 2) f[62:52] = 11'(1000 + $urandom_range(0, 90));
        if ($urandom_range(0, 2) == 0) f[51:0] = f[51:0] & ({52{1'b1}} << $urandom_range(0, 52));
        return f;
    endfunction

    task automatic convert(input logic [63:0] f, input logic [1:0] rm,
                           output logic [63:0] r, output logic inv, output logic inx, output int lat);
        @(negedge clk);
        in_valid = 1'b1;
        fp_in = f;
`ifdef FP2INT_RMODE_EN
        rmode = rm;
`endif
        chk("in_ready", {63'd0, rdy}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        fp_in = {$urandom, $urandom};
`ifdef FP2INT_RMODE_EN
        rmode = 2'($urandom);
`endif
        lat = 1;
        while (!ov && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("timeout", {63'd0, ov}, 64'd1);
        r = iout;
        inv = inv_o;
        inx = inx_o;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("out_valid_drop", {63'd0, ov}, 64'd0);
    endtask

    logic [63:0] dv[10] = '{64'h3ff8000000000000, 64'h4004000000000000, 64'hc008000000000000,
                            64'h43d0000000000000, 64'hc3e0000000000000, 64'h43e0000000000000,
                            64'h7ff8000000000000, 64'hfff0000000000000, 64'h0000000000000001,
                            64'h8000000000000000};
    logic [63:0] dr[10] = '{64'd2, 64'd2, 64'hffff_ffff_ffff_fffd, 64'h4000_0000_0000_0000, MINN,
                            MAXP, MINN, MINN, 64'd0, 64'd0};
    logic [1:0]  df[10] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b01, 2'b00};

    initial begin
        logic [63:0] r, er, f;
        logic inv, inx, ei, ex;
        logic [1:0] rm;
        int lat;
        #2 rst_n = 1'b0;
        #20;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk("rst_in_ready", {63'd0, rdy}, 64'd1);
            chk("rst_out_valid", {63'd0, ov}, 64'd0);
            chk("rst_int_out", iout, 64'd0);
            chk("rst_flags", {62'd0, inv_o, inx_o}, 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            for (int i = 0; i < 10; i++) begin
                convert(dv[i], 2'b00, r, inv, inx, lat);
                chk($sformatf("dir_res_%0d", i), r, dr[i]);
                chk($sformatf("dir_flags_%0d", i), {62'd0, inv, inx}, {62'd0, df[i]});
            end
        end

        sel = 1'b0;
        convert(64'h3ff0000000000000, 2'b00, r, inv, inx, lat);
        chk("lat_step8", 64'(lat), 64'd9);
        chk("lat_step8_res", r, 64'd1);
        sel = 1'b1;
        convert(64'h3ff0000000000000, 2'b00, r, inv, inx, lat);
        chk("lat_step1", 64'(lat), 64'd54);
        chk("lat_step1_res", r, 64'd1);

        sel = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        fp_in = 64'h4004000000000000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!ov && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("hold_timeout", {63'd0, ov}, 64'd1);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            fp_in = 64'h4059000000000000;
            @(posedge clk);
            #1;
            chk("hold_valid", {63'd0, ov}, 64'd1);
            chk("hold_res", iout, 64'd2);
            chk("hold_flags", {62'd0, inv_o, inx_o}, 64'd1);
            chk("hold_in_ready", {63'd0, rdy}, 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_hs_idle", {63'd0, rdy}, 64'd1);
        chk("post_hs_valid", {63'd0, ov}, 64'd0);
        chk("post_hs_keep", iout, 64'd2);

        sel = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        fp_in = 64'h3ff0000000000000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_shift_busy", {63'd0, rdy}, 64'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", {63'd0, rdy}, 64'd1);
        chk("abort_out_valid", {63'd0, ov}, 64'd0);
        chk("abort_int_out", iout, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef FP2INT_RMODE_EN
        sel = 1'b0;
        for (int m = 1; m < 4; m++) begin
            convert(64'hbfe0000000000000, 2'(m), r, inv, inx, lat);
            chk($sformatf("rmode%0d_res", m), r, (m == 3) ? MAXP | MINN : 64'd0);
            chk($sformatf("rmode%0d_inx", m), {63'd0, inx}, 64'd1);
        end
`endif

        for (int i = 0; i < 360; i++) begin
            sel = (i % 4 == 3);
            f = gen();
`ifdef FP2INT_RMODE_EN
            rm = 2'($urandom);
`else
            rm = 2'b00;
`endif
            model(f, rm, er, ei, ex);
            convert(f, rm, r, inv, inx, lat);
            chk($sformatf("rnd_res_%h_m%0d", f, rm), r, er);
            chk($sformatf("rnd_inv_%h", f), {63'd0, inv}, {63'd0, ei});
            chk($sformatf("rnd_inx_%h", f), {63'd0, inx}, {63'd0, ex});
            chk($sformatf("rnd_lat_%h", f), 64'(lat), 64'(exp_lat(f, sel ? 1 : 8)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
